// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: shared states, opcodes, ALU selects and control bundle for the multicycle core
package multicycle_control_pkg;
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8
    } state_t;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    typedef struct packed {
        logic       pc_write;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
        logic       illegal_op;
        logic       bus_error;
    } ctl_t;
endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// mem_wait_timer: counts stalled memory cycles and flags the one where the wait budget runs out
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    output logic timeout
);
    logic [CNT_W-1:0] cnt;
    logic             stall;
    assign stall   = active && !ready;
    assign timeout = stall && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    // Any cycle that is not a continued stall restarts the count, so every entry sees zero
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= (stall && !timeout) ? ((&cnt) ? cnt : cnt + CNT_W'(1)) : '0;
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main sequencing FSM for the multicycle RISC-V datapath
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic       pcSource,
    output logic       illegalOp,
    output logic       busError,
    output logic [3:0] state
);
    state_t cur, nxt;
    ctl_t   c, q;
    logic   timeout;
    mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_timer (
        .clk(clk),
        .reset(reset),
        .active(cur == S_FETCH || cur == S_MEM_READ || cur == S_MEM_WRITE),
        .ready(memReady),
        .timeout(timeout)
    );
    always_ff @(posedge clk) begin
        if (reset)
            cur <= S_FETCH;
        else
            cur <= nxt;
    end
    always_comb begin
        c = '0;
        nxt = S_FETCH;
        c.bus_error = timeout;
        case (cur)
            S_FETCH: begin
                c.mem_read = !timeout;
                c.alu_src_b = SRCB_FOUR;
                c.ir_write = memReady;
                c.pc_write = memReady;
                nxt = memReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM;
                nxt = (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEM_ADDR :
                      opcode == OP_RTYPE  ? S_EXECUTE :
                      opcode == OP_BRANCH ? S_BRANCH : S_FETCH;
                c.illegal_op = nxt == S_FETCH;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                nxt = opcode == OP_STORE ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                c.ior_d = 1'b1;
                c.mem_read = !timeout;
                nxt = memReady ? S_MEM_WB : timeout ? S_FETCH : S_MEM_READ;
            end
            S_MEM_WB: begin
                c.reg_write = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.ior_d = 1'b1;
                c.mem_write = !timeout;
                nxt = (memReady || timeout) ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op = ALUOP_FUNCT;
                nxt = S_ALU_WB;
            end
            S_ALU_WB: c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op = ALUOP_SUB;
                c.pc_source = 1'b1;
                c.pc_write = zero;
            end
            default: nxt = S_FETCH;
        endcase
        q = reset ? '0 : c;
    end
    assign pcWrite   = q.pc_write;
    assign iorD      = q.ior_d;
    assign memRead   = q.mem_read;
    assign memWrite  = q.mem_write;
    assign irWrite   = q.ir_write;
    assign memToReg  = q.mem_to_reg;
    assign regWrite  = q.reg_write;
    assign aluSrcA   = q.alu_src_a;
    assign aluSrcB   = q.alu_src_b;
    assign aluOp     = q.alu_op;
    assign pcSource  = q.pc_source;
    assign illegalOp = q.illegal_op;
    assign busError  = q.bus_error;
    assign state     = cur;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: instruction-level reference model driving randomized and directed control sequences
module tb_multicycle_control;
    localparam int T = 15;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, BR = 7'b1100011;
    localparam logic [18:0] PCW = 19'h40000, IORD = 19'h20000, MR = 19'h10000, MW = 19'h08000;
    localparam logic [18:0] IRW = 19'h04000, M2R = 19'h02000, RW = 19'h01000, ASA = 19'h00800;
    localparam logic [18:0] BIMM = 19'h00400, BFOUR = 19'h00200, AOFN = 19'h00100, AOSUB = 19'h00080;
    localparam logic [18:0] PCS = 19'h00040, ILL = 19'h00020, BE = 19'h00010;
    typedef struct {
        logic        rdy;
        logic        z;
        logic [6:0]  op;
        logic [18:0] exp;
    } cyc_t;
    logic clk = 0, reset = 1, zero = 0, memReady = 0;
    logic [6:0] opcode = 0;
    logic pcWrite, iorD, memRead, memWrite, irWrite, memToReg, regWrite, aluSrcA, pcSource, illegalOp, busError;
    logic [1:0] aluSrcB, aluOp;
    logic [3:0] state;
    logic [18:0] obs;
    logic [6:0] cur_op;
    cyc_t q[$];
    int total = 0, bad = 0;
    multicycle_control #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
        .pcWrite(pcWrite), .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
        .irWrite(irWrite), .memToReg(memToReg), .regWrite(regWrite), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource), .illegalOp(illegalOp),
        .busError(busError), .state(state)
    );
    assign obs = {pcWrite, iorD, memRead, memWrite, irWrite, memToReg, regWrite, aluSrcA,
                  aluSrcB, aluOp, pcSource, illegalOp, busError, state};
    always #5 clk = ~clk;
    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction
    task automatic push(input logic rdy, input logic z, input logic [18:0] e);
        cyc_t c;
        c.rdy = rdy; c.z = z; c.op = cur_op; c.exp = e;
        q.push_back(c);
    endtask
    // A memory phase lasts lat stalled cycles plus one completing cycle, or times out after T stalls
    task automatic mem_phase(input logic [18:0] st, input logic [18:0] base, input logic [18:0] done_extra,
                             input int lat, output logic ok);
        if (lat >= T) begin
            for (int i = 0; i < T - 1; i++) push(1'b0, rb(), st | base);
            push(1'b0, rb(), (st | base | BE) & ~(MR | MW));
            ok = 1'b0;
        end else begin
            for (int i = 0; i < lat; i++) push(1'b0, rb(), st | base);
            push(1'b1, rb(), st | base | done_extra);
            ok = 1'b1;
        end
    endtask
    task automatic plan(input logic [6:0] op, input logic z, input int lf, input int lm);
        logic ok;
        cur_op = op;
        mem_phase(19'd0, MR | BFOUR, PCW | IRW, lf, ok);
        if (!ok) return;
        if (op == LW || op == SW) begin
            push(rb(), rb(), 19'd1 | BIMM);
            push(rb(), rb(), 19'd2 | ASA | BIMM);
            mem_phase(op == LW ? 19'd3 : 19'd5, IORD | (op == LW ? MR : MW), 19'd0, lm, ok);
            if (ok && op == LW) push(rb(), rb(), 19'd4 | RW | M2R);
        end else if (op == RT) begin
            push(rb(), rb(), 19'd1 | BIMM);
            push(rb(), rb(), 19'd6 | ASA | AOFN);
            push(rb(), rb(), 19'd7 | RW);
        end else if (op == BR) begin
            push(rb(), rb(), 19'd1 | BIMM);
            push(rb(), z, 19'd8 | ASA | AOSUB | PCS | (z ? PCW : 19'd0));
        end else begin
            push(rb(), rb(), 19'd1 | BIMM | ILL);
        end
    endtask
    task automatic run_plan(input string name);
        cyc_t c;
        int n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            memReady = c.rdy; zero = c.z; opcode = c.op;
            #1;
            total++;
            if (obs !== c.exp) begin
                bad++;
                $display("FAIL %s cycle %0d: got %h want %h (state %0d)", name, n, obs, c.exp, state);
            end
            n++;
        end
    endtask
    task automatic step_check(input string name, input logic r, input logic rdy, input logic [18:0] mask,
                              input logic [18:0] e);
        @(negedge clk);
        reset = r; memReady = rdy;
        #1;
        total++;
        if ((obs & mask) !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, obs & mask, e);
        end
    endtask
    task automatic test_reset();
        opcode = LW;
        for (int i = 0; i < 3; i++) step_check("reset_init", 1'b1, rb(), 19'h7FFFF, 19'd0);
        step_check("rst_fetch", 1'b0, 1'b1, 19'h7FFFF, 19'd0 | MR | BFOUR | PCW | IRW);
        step_check("rst_decode", 1'b0, 1'b0, 19'h7FFFF, 19'd1 | BIMM);
        step_check("rst_memaddr", 1'b0, 1'b0, 19'h7FFFF, 19'd2 | ASA | BIMM);
        step_check("rst_memread", 1'b0, 1'b0, 19'h7FFFF, 19'd3 | IORD | MR);
        step_check("reset_mid_outs", 1'b1, 1'b0, 19'h7FFF0, 19'd0);
        step_check("reset_mid_1", 1'b1, 1'b1, 19'h7FFFF, 19'd0);
        step_check("reset_mid_2", 1'b1, 1'b0, 19'h7FFFF, 19'd0);
        step_check("reset_release", 1'b0, 1'b0, 19'h7FFFF, 19'd0 | MR | BFOUR);
        step_check("reset_resync", 1'b1, 1'b0, 19'h7FFFF, 19'd0);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
    endtask
    task automatic test_rtype();
        plan(RT, 1'b0, 0, 0); run_plan("rtype");
    endtask
    task automatic test_load();
        plan(LW, 1'b0, 0, 0); run_plan("load");
    endtask
    task automatic test_branch();
        plan(BR, 1'b1, 0, 0); run_plan("beq_taken");
        plan(BR, 1'b0, 0, 0); run_plan("beq_not_taken");
    endtask
    task automatic test_store_wait();
        plan(SW, 1'b0, 0, T - 1); run_plan("store_wait_max");
        plan(SW, 1'b0, 0, T); run_plan("store_timeout");
    endtask
    task automatic test_fetch_timeout();
        plan(LW, 1'b0, T, 0); run_plan("fetch_timeout");
        plan(LW, 1'b0, T - 1, T - 1); run_plan("load_wait_max");
        plan(LW, 1'b0, 3, T + 4); run_plan("load_timeout");
    endtask
    task automatic test_illegal();
        plan(7'b0010011, 1'b0, 0, 0); run_plan("illegal");
    endtask
    task automatic test_back_to_back();
        logic [6:0] op;
        int sel;
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 5);
            op = sel == 0 ? LW : sel == 1 ? SW : sel == 2 ? RT : sel == 3 ? BR : 7'($urandom);
            plan(op, rb(), $urandom_range(0, 3) == 0 ? $urandom_range(0, T + 2) : 0,
                 $urandom_range(0, 2) == 0 ? $urandom_range(0, T + 2) : $urandom_range(0, 2));
        end
        run_plan("random");
    endtask
    initial begin
        test_reset();
        test_rtype();
        test_load();
        test_branch();
        test_store_wait();
        test_fetch_timeout();
        test_illegal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle RISC-V datapath (subset: lw, sw, R-type add/sub/and/or, beq).
- Sequences PC, instruction register, shared memory port, register file and ALU over 3–5 cycles per instruction.
- Drives the 2-bit aluOp consumed by the ALU control decoder: 00 = add, 01 = subtract/compare, 10 = funct-decoded.
- Handles variable-latency memory with a ready handshake and a timeout.

Parameters:
- TIMEOUT_CYCLES, 15, maximum cycles spent waiting for memReady in any memory state before aborting (1..255).
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instr[6:0] from the instruction register (valid from DECODE onward).
- zero  in  1  ALU zero flag.
- memReady  in  1  memory has completed the current read/write this cycle.
- pcWrite  out  1  load PC.
- iorD  out  1  memory address source: 0 = PC, 1 = ALUOut.
- memRead  out  1  memory read request.
- memWrite  out  1  memory write request.
- irWrite  out  1  load instruction register.
- memToReg  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- regWrite  out  1  register file write enable.
- aluSrcA  out  1  ALU operand A: 0 = PC, 1 = register A.
- aluSrcB  out  2  ALU operand B: 00 = register B, 01 = constant 4, 10 = immediate.
- aluOp  out  2  to ALU control: 00 add, 01 sub, 10 funct.
- pcSource  out  1  PC input: 0 = ALU result, 1 = ALUOut.
- illegalOp  out  1  one-cycle pulse: unsupported opcode seen in DECODE.
- busError  out  1  one-cycle pulse: memory wait timed out.
- state  out  4  current state encoding, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8. Codes 9–15 are illegal and go to FETCH.
- Reset: in the cycle reset is sampled, state <= FETCH and waitCnt <= 0. While reset is high, every output except state is forced to 0. Reset mid-instruction abandons it with no further writes.
- Outputs are Moore, decoded from state, except the qualified strobes noted below. Any output not listed for a state is 0.
- FETCH: iorD=0, memRead=1, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=0.
  - irWrite = pcWrite = memReady.
  - memReady=1 -> DECODE; otherwise stay.
- DECODE: aluSrcA=0, aluSrcB=10, aluOp=00 (branch target precomputed into ALUOut).
  - Opcode dispatch: 0000011 or 0100011 -> MEM_ADDR; 0110011 -> EXECUTE; 1100011 -> BRANCH.
  - Any other opcode: illegalOp=1 for this cycle, -> FETCH.
- MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOp=00. Then lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: iorD=1, memRead=1. Stay until memReady, then -> MEM_WB.
- MEM_WB: regWrite=1, memToReg=1. -> FETCH.
- MEM_WRITE: iorD=1, memWrite=1. Stay until memReady, then -> FETCH.
- EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10. -> ALU_WB.
- ALU_WB: regWrite=1, memToReg=0. -> FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcSource=1, pcWrite=zero (Mealy). -> FETCH.
- Opcode use: the opcode is sampled only in DECODE and MEM_ADDR. The instruction register is stable after FETCH, so no latch is required.
- Wait counter (shared by FETCH, MEM_READ, MEM_WRITE):
  - waitCnt clears on entry to any memory state and increments each cycle that state is held with memReady=0.
  - If waitCnt == TIMEOUT_CYCLES-1 and memReady=0: busError=1 for that cycle, request strobes drop, state -> FETCH, no PC/IR/register write.
  - The counter saturates and never wraps.
  - memReady=1 in the timeout cycle takes priority: the access completes normally and busError stays 0.
- Latency with memReady tied high: lw 5, sw 4, R-type 4, beq 3 cycles.
- memRead and memWrite are never high in the same cycle. regWrite and pcWrite are never high in the same cycle.

Decomposition:
- Shared package/header:
  - state localparams (S_FETCH..S_BRANCH);
  - opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH;
  - aluOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10, also used by the ALU control decoder;
  - aluSrcB select constants.
- One sub-module: mem_wait_timer (clear, hold, ready -> timeout pulse), parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset held 3 cycles mid-MEM_READ -> state=0 and all strobes 0 during reset; the first cycle after release shows memRead=1, iorD=0.
- memReady=1, opcode=0110011 -> states 0,1,6,7,0; aluOp=10 only in EXECUTE; a single regWrite pulse with memToReg=0.
- memReady=1, opcode=0000011 -> states 0,1,2,3,4,0; regWrite=1 with memToReg=1 in MEM_WB; iorD=1 in MEM_READ.
- opcode=1100011 with zero=1, then zero=0 -> pcWrite=1 with pcSource=1 in BRANCH for the first run; pcWrite=0 for the second; aluOp=01 in both.
- sw with memReady low for 14 cycles then high on cycle 15 -> memWrite held 15 cycles, busError=0, then FETCH. Repeat with memReady never high -> busError pulses once at wait cycle 15, return to FETCH, no writes.
- opcode=0010011 -> illegalOp pulses in DECODE, next state FETCH, no regWrite/memWrite at any point.
